float_cmp_param: RTL and testbench

Multi-cycle IEEE-754 comparator, parametrised in exponent and fraction width. It is the successor to the fixed 32-bit float compare used by the MIPS FP compare instructions. It adds correct NaN/unordered handling, +0 == -0, denormal ordering, a magnitude-compare mode and an invalid flag. It sits beside the FPU datapath and uses the same execute/ready handshake toward the control unit.

---
 rtl/float_cmp_pkg.sv | 29 ++
 rtl/fp_classify.sv | 30 +++
 rtl/float_cmp_param.sv | 119 +++++++++++
 tb/tb_float_cmp_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/float_cmp_pkg.sv
// Shared types and encodings for the parametrised IEEE-754 comparator.
package float_cmp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    EXP_CMP  = 3'd2,
    FRAC_CMP = 3'd3,
    DONE     = 3'd4
  } cmp_state_t;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b11;
  localparam logic [1:0] CMP_UN = 2'b10;

  localparam logic MODE_SIGNED = 1'b0;
  localparam logic MODE_MAG    = 1'b1;

  // Swap greater/less; equal and unordered pass through.
  function automatic logic [1:0] cmp_invert(input logic [1:0] r);
    case (r)
      CMP_GT:  return CMP_LT;
      CMP_LT:  return CMP_GT;
      default: return r;
    endcase
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Field split and class detection for one IEEE-754 operand.
module fp_classify #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] x,
  output logic                  is_nan,
  output logic                  is_snan,
  output logic                  is_zero,
  output logic                  is_inf,
  output logic                  sign,
  output logic [EXP_W-1:0]      exp,
  output logic [FRAC_W-1:0]     frac
);

  logic exp_ones, frac_nz;

  assign sign     = x[EXP_W+FRAC_W];
  assign exp      = x[EXP_W+FRAC_W-1:FRAC_W];
  assign frac     = x[FRAC_W-1:0];
  assign exp_ones = &exp;
  assign frac_nz  = |frac;

  assign is_nan  = exp_ones & frac_nz;
  // Quiet bit is the fraction MSB; clear means signalling.
  assign is_snan = is_nan & ~frac[FRAC_W-1];
  assign is_zero = ~(|exp) & ~frac_nz;
  assign is_inf  = exp_ones & ~frac_nz;

endmodule

// File: rtl/float_cmp_param.sv
// Multi-cycle IEEE-754 compare: CLASSIFY -> EXP_CMP -> FRAC_CMP -> DONE.
module float_cmp_param
  import float_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  execute,
  input  logic [EXP_W+FRAC_W:0] A,
  input  logic [EXP_W+FRAC_W:0] B,
  input  logic                  mode,
  output logic [1:0]            out,
  output logic                  ready,
  output logic                  busy,
  output logic                  invalid
);

  localparam int W = 1 + EXP_W + FRAC_W;

  cmp_state_t state;

  // Index 0 = operand A, index 1 = operand B.
  logic [1:0][W-1:0]      op_q;
  logic                   mode_q;
  logic [1:0]             nan_c, snan_c, zero_c, inf_c, sign_c;
  logic [1:0][EXP_W-1:0]  exp_c;
  logic [1:0][FRAC_W-1:0] frac_c;
  logic [1:0]             nan_q, snan_q, zero_q, inf_q, sign_q;
  logic                   exp_gt_q, exp_lt_q;
  logic [1:0]             mag_res, res;

  for (genvar i = 0; i < 2; i++) begin : g_cls
    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls (
      .x       (op_q[i]),
      .is_nan  (nan_c[i]),
      .is_snan (snan_c[i]),
      .is_zero (zero_c[i]),
      .is_inf  (inf_c[i]),
      .sign    (sign_c[i]),
      .exp     (exp_c[i]),
      .frac    (frac_c[i])
    );
  end

  // Unsigned order of {exp,frac} is magnitude order, denormals included.
  always_comb begin
    mag_res = CMP_EQ;
    if (&inf_q)                      mag_res = CMP_EQ;
    else if (exp_gt_q)               mag_res = CMP_GT;
    else if (exp_lt_q)               mag_res = CMP_LT;
    else if (frac_c[0] > frac_c[1])  mag_res = CMP_GT;
    else if (frac_c[0] < frac_c[1])  mag_res = CMP_LT;
  end

  always_comb begin
    res = mag_res;
    if (|nan_q)                      res = CMP_UN;
    else if (&zero_q)                res = CMP_EQ;
    else if (mode_q == MODE_MAG)     res = mag_res;
    else if (sign_q[0] != sign_q[1]) res = sign_q[0] ? CMP_LT : CMP_GT;
    else if (!sign_q[0])             res = mag_res;
    else                             res = cmp_invert(mag_res);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      mode_q   <= MODE_SIGNED;
      nan_q    <= '0;
      snan_q   <= '0;
      zero_q   <= '0;
      inf_q    <= '0;
      sign_q   <= '0;
      exp_gt_q <= 1'b0;
      exp_lt_q <= 1'b0;
      out      <= CMP_EQ;
      ready    <= 1'b0;
      busy     <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (execute) begin
            op_q   <= {B, A};
            mode_q <= mode;
            busy   <= 1'b1;
            ready  <= 1'b0;
            state  <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          nan_q  <= nan_c;
          snan_q <= snan_c;
          zero_q <= zero_c;
          inf_q  <= inf_c;
          sign_q <= sign_c;
          state  <= EXP_CMP;
        end
        EXP_CMP: begin
          exp_gt_q <= exp_c[0] > exp_c[1];
          exp_lt_q <= exp_c[0] < exp_c[1];
          state    <= FRAC_CMP;
        end
        FRAC_CMP: begin
          out     <= res;
          invalid <= |snan_q;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_cmp_param.sv
// Bench for float_cmp_param: single- and half-precision instances, vector table plus random model check.
module tb_float_cmp_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex32, ex16, m32, m16;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic [1:0]  out32, out16;
  logic        rdy32, rdy16, bsy32, bsy16, inv32, inv16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  float_cmp_param u_sp (
    .clk(clk), .reset(reset), .execute(ex32), .A(a32), .B(b32), .mode(m32),
    .out(out32), .ready(rdy32), .busy(bsy32), .invalid(inv32)
  );

  float_cmp_param #(.EXP_W(5), .FRAC_W(10)) u_hp (
    .clk(clk), .reset(reset), .execute(ex16), .A(a16), .B(b16), .mode(m16),
    .out(out16), .ready(rdy16), .busy(bsy16), .invalid(inv16)
  );

  typedef struct {
    string       name;
    bit          half;
    logic [31:0] a, b;
    logic        m;
    logic [1:0]  eo;
    logic        ei;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference: sign-magnitude to signed integer gives IEEE order for non-NaN values.
  function automatic logic [1:0] ref_cmp(input int ew, input int fw, input longint unsigned a,
                                         input longint unsigned b, input logic m, output logic inv);
    longint unsigned emask, fmask, mmask, ea, eb, fa, fb, ma, mb;
    longint va, vb;
    bit na, nb, sa, sb;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << fw) - 1;
    mmask = (64'd1 << (ew + fw)) - 1;
    ea = (a >> fw) & emask;  eb = (b >> fw) & emask;
    fa = a & fmask;          fb = b & fmask;
    ma = a & mmask;          mb = b & mmask;
    sa = ((a >> (ew + fw)) & 1) != 0;
    sb = ((b >> (ew + fw)) & 1) != 0;
    na = (ea == emask) && (fa != 0);
    nb = (eb == emask) && (fb != 0);
    inv = (na && ((fa >> (fw - 1)) & 1) == 0) || (nb && ((fb >> (fw - 1)) & 1) == 0);
    if (na || nb) return 2'b10;
    if (ma == 0 && mb == 0) return 2'b00;
    va = longint'(ma);
    vb = longint'(mb);
    if (!m) begin
      if (sa) va = -va;
      if (sb) vb = -vb;
    end
    if (va > vb) return 2'b01;
    if (va < vb) return 2'b11;
    return 2'b00;
  endfunction

  // Launch one compare and wait for ready; lat counts falling edges after the capture edge.
  task automatic do_cmp(input bit half, input logic [31:0] a, input logic [31:0] b, input logic m,
                        output logic [1:0] o, output logic inv, output int lat, output bit bsy_ok);
    @(negedge clk);
    if (half) begin a16 = a[15:0]; b16 = b[15:0]; m16 = m; ex16 = 1'b1; end
    else      begin a32 = a;       b32 = b;       m32 = m; ex32 = 1'b1; end
    @(negedge clk);
    ex16 = 1'b0; ex32 = 1'b0;
    lat = 1;
    bsy_ok = 1'b1;
    while (!(half ? rdy16 : rdy32) && lat < 20) begin
      if (!(half ? bsy16 : bsy32)) bsy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (half ? bsy16 : bsy32) bsy_ok = 1'b0;
    o   = half ? out16 : out32;
    inv = half ? inv16 : inv32;
  endtask

  initial begin
    logic [1:0]  o, eo;
    logic        inv, ei;
    int          lat;
    bit          bok;
    logic [31:0] ra, rb;
    logic        rm;

    reset = 1'b1;
    ex32 = 1'b0; ex16 = 1'b0; m32 = 1'b0; m16 = 1'b0;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out",   {30'd0, out32}, 32'd0);
    chk("rst_ready", {31'd0, rdy32}, 32'd0);
    chk("rst_busy",  {31'd0, bsy32}, 32'd0);
    chk("rst_inv",   {31'd0, inv32}, 32'd0);
    chk("rst_hp",    {27'd0, out16, rdy16, bsy16, inv16}, 32'd0);
    reset = 1'b0;

    tbl.push_back('{"one_lt_two", 0, 32'h3F800000, 32'h40000000, 1'b0, 2'b11, 1'b0});
    tbl.push_back('{"negz_eq_z",  0, 32'h80000000, 32'h00000000, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{"neg_signed", 0, 32'hC0000000, 32'hBF800000, 1'b0, 2'b11, 1'b0});
    tbl.push_back('{"neg_mag",    0, 32'hC0000000, 32'hBF800000, 1'b1, 2'b01, 1'b0});
    tbl.push_back('{"qnan",       0, 32'h7FC00000, 32'h3F800000, 1'b0, 2'b10, 1'b0});
    tbl.push_back('{"snan",       0, 32'h7F800001, 32'h3F800000, 1'b0, 2'b10, 1'b1});
    tbl.push_back('{"snan_b_mag", 0, 32'h3F800000, 32'hFF800001, 1'b1, 2'b10, 1'b1});
    tbl.push_back('{"inf_gt_max", 0, 32'h7F800000, 32'h7F7FFFFF, 1'b0, 2'b01, 1'b0});
    tbl.push_back('{"ninf_lt",    0, 32'hFF800000, 32'hFF7FFFFF, 1'b0, 2'b11, 1'b0});
    tbl.push_back('{"denorm",     0, 32'h00000001, 32'h00800000, 1'b0, 2'b11, 1'b0});
    tbl.push_back('{"den_eq",     0, 32'h00400000, 32'h00400000, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{"sign_diff",  0, 32'hBF800000, 32'h3F800000, 1'b0, 2'b11, 1'b0});
    tbl.push_back('{"mag_eq",     0, 32'hBF800000, 32'h3F800000, 1'b1, 2'b00, 1'b0});
    tbl.push_back('{"mag_zeros",  0, 32'h80000000, 32'h00000000, 1'b1, 2'b00, 1'b0});
    tbl.push_back('{"hp_one",     1, 32'h3C00,     32'hBC00,     1'b0, 2'b01, 1'b0});
    tbl.push_back('{"hp_qnan",    1, 32'h7E00,     32'h0000,     1'b0, 2'b10, 1'b0});
    tbl.push_back('{"hp_zero",    1, 32'h8000,     32'h0000,     1'b0, 2'b00, 1'b0});
    tbl.push_back('{"hp_snan",    1, 32'h7C01,     32'h0000,     1'b0, 2'b10, 1'b1});

    foreach (tbl[i]) begin
      do_cmp(tbl[i].half, tbl[i].a, tbl[i].b, tbl[i].m, o, inv, lat, bok);
      chk({tbl[i].name, "_out"}, {30'd0, o}, {30'd0, tbl[i].eo});
      chk({tbl[i].name, "_inv"}, {31'd0, inv}, {31'd0, tbl[i].ei});
      chk({tbl[i].name, "_lat"}, lat, 32'd4);
      chk({tbl[i].name, "_busy"}, {31'd0, bok}, 32'd1);
    end

    // Execute while busy is ignored; old result held until the new DONE.
    do_cmp(0, 32'h7F800000, 32'h7F7FFFFF, 1'b0, o, inv, lat, bok);
    @(negedge clk);
    a32 = 32'h3F800000; b32 = 32'h40000000; m32 = 1'b0; ex32 = 1'b1;
    @(negedge clk);
    ex32 = 1'b0;
    @(negedge clk);
    a32 = 32'h40000000; b32 = 32'h3F800000; ex32 = 1'b1;
    chk("busy_hold_out", {30'd0, out32}, 32'd1);
    chk("busy_flag",     {31'd0, bsy32}, 32'd1);
    @(negedge clk);
    ex32 = 1'b0;
    chk("busy_not_ready", {31'd0, rdy32}, 32'd0);
    @(negedge clk);
    chk("busy_ign_ready", {31'd0, rdy32}, 32'd1);
    chk("busy_ign_out",   {30'd0, out32}, 32'd3);
    repeat (5) @(negedge clk);
    chk("ready_stays", {29'd0, rdy32, out32}, 32'h7);

    // Reset during FRAC_CMP clears held sNaN result at once.
    do_cmp(0, 32'h7F800001, 32'h0, 1'b0, o, inv, lat, bok);
    chk("pre_rst_inv", {31'd0, inv}, 32'd1);
    @(negedge clk);
    a32 = 32'h3F800000; b32 = 32'h40000000; ex32 = 1'b1;
    @(negedge clk);
    ex32 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst", {27'd0, out32, rdy32, bsy32, inv32}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_cmp(0, 32'h40000000, 32'h3F800000, 1'b0, o, inv, lat, bok);
    chk("post_rst_out", {30'd0, o}, 32'd1);
    chk("post_rst_lat", lat, 32'd4);

    for (int i = 0; i < 160; i++) begin
      ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = ra ^ 32'h80000000;
        2: ra[30:23] = 8'hFF;
        3: begin ra = ra & 32'h807FFFFF; rb = rb & 32'h807FFFFF; end
        4: rb[30:23] = ra[30:23];
        default: ra = {ra[31], 31'd0};
      endcase
      eo = ref_cmp(8, 23, 64'(ra), 64'(rb), rm, ei);
      do_cmp(0, ra, rb, rm, o, inv, lat, bok);
      chk("rnd_sp", {29'd0, inv, o}, {29'd0, ei, eo});
    end

    for (int i = 0; i < 60; i++) begin
      ra = {16'd0, 16'($urandom)}; rb = {16'd0, 16'($urandom)}; rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb[14:10] = ra[14:10];
        1: ra[14:10] = 5'h1F;
        2: rb = ra ^ 32'h8000;
        default: ;
      endcase
      eo = ref_cmp(5, 10, 64'(ra), 64'(rb), rm, ei);
      do_cmp(1, ra, rb, rm, o, inv, lat, bok);
      chk("rnd_hp", {29'd0, inv, o}, {29'd0, ei, eo});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
